// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: state encodings, handshake
// levels, widths and the two's-complement helpers used by the sign logic.
package div_ctrl_pkg;

  localparam int OP_W  = 32;
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] LastStep = 6'd32;
  localparam logic [CNT_W-1:0] CntOne   = 6'd1;
  localparam logic [OP_W-1:0]  WordOne  = 32'd1;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic [OP_W-1:0] twos_neg(input logic [OP_W-1:0] v);
    return ~v + WordOne;
  endfunction

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[OP_W-1]) ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor, subtract when it fits and report the resulting quotient bit.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [OP_W:0]   partial,
  input  logic [OP_W-1:0] divisor,
  output logic [OP_W-1:0] remainder,
  output logic            q_bit
);

  // partial < 2*divisor always holds, so the difference fits in OP_W bits.
  always_comb begin
    q_bit     = (partial >= {1'b0, divisor});
    remainder = q_bit ? (partial[OP_W-1:0] - divisor) : partial[OP_W-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit: latches magnitudes, runs 32 restoring steps,
// applies the sign fix-up and holds {remainder, quotient} until released.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   quo_reg, quo_next;
  logic [DATA_W-1:0]   rem_reg, rem_next;
  logic [DATA_W-1:0]   divisor_reg, divisor_next;
  logic                neg_q_reg, neg_q_next;
  logic                neg_r_reg, neg_r_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic                ready_reg, ready_next;

  logic              accept;
  logic [DATA_W:0]   partial;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;

  assign accept = (start_i == DivStart) && !annul_i;

  // The dividend shifts out of the quotient register MSB first while
  // quotient bits shift in at the bottom.
  assign partial = {rem_reg, quo_reg[DATA_W-1]};

  div_step u_step (
    .partial   (partial),
    .divisor   (divisor_reg),
    .remainder (step_rem),
    .q_bit     (step_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DivFree;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DivFree: begin
        if (accept) begin
          state_next = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        state_next = annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        if (annul_i) begin
          state_next = DivFree;
        end else if (cnt_reg == LastStep) begin
          state_next = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_next = DivFree;
        end
      end
      default: state_next = DivFree;
    endcase
  end

  always_comb begin
    cnt_next     = cnt_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    divisor_next = divisor_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;
    case (state_reg)
      DivFree: begin
        result_next = '0;
        ready_next  = DivResultNotReady;
        if (accept) begin
          cnt_next     = '0;
          rem_next     = '0;
          quo_next     = magnitude(opdata1_i, signed_div_i);
          divisor_next = magnitude(opdata2_i, signed_div_i);
          neg_q_next   = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r_next   = signed_div_i && opdata1_i[DATA_W-1];
        end
      end
      DivByZero: begin
        result_next = '0;
        ready_next  = annul_i ? DivResultNotReady : DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          result_next = '0;
          ready_next  = DivResultNotReady;
        end else if (cnt_reg != LastStep) begin
          rem_next = step_rem;
          quo_next = {quo_reg[DATA_W-2:0], step_q};
          cnt_next = cnt_reg + CntOne;
        end else begin
          result_next = {neg_r_reg ? twos_neg(rem_reg) : rem_reg,
                         neg_q_reg ? twos_neg(quo_reg) : quo_reg};
          ready_next  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          result_next = '0;
          ready_next  = DivResultNotReady;
        end
      end
      default: begin
        result_next = '0;
        ready_next  = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= DivResultNotReady;
    end else begin
      cnt_reg     <= cnt_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      divisor_reg <= divisor_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port signed_div_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned).
REQ-005 SHALL have port opdata1_i  input  32  dividend (rs).
REQ-006 SHALL have port opdata2_i  input  32  divisor (rt).
REQ-007 SHALL have port start_i  input  1  EX-stage request; held high until ready_o is seen.
REQ-008 SHALL have port annul_i  input  1  cancel request (flush in progress).
REQ-009 SHALL have port result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-010 SHALL have port ready_o  output  1  result_o valid.

Function
REQ-011 SHALL implement four states: FREE, BYZERO, ON, END.
REQ-012 In FREE, an edge with start_i=1 and annul_i=0 SHALL accept the request (edge E0); otherwise the block SHALL stay in FREE.
- Acceptance with opdata2_i==0 -> BYZERO.
- Acceptance with opdata2_i!=0 -> ON, with iteration counter cleared to 0.
REQ-013 Operands and signed_div_i SHALL be latched at E0; later input changes SHALL be ignored.
REQ-014 For a signed request, the magnitudes of both operands SHALL be latched (two's-complement negate if bit 31 set); 0x80000000 SHALL remain 0x80000000 when treated as unsigned.
REQ-015 ON SHALL perform restoring division, one quotient bit per edge, MSB first, over edges E1..E32; the counter SHALL increment each edge.
- Each step compares a 33-bit partial remainder with the divisor.
- Remainder >= divisor -> subtract and shift in 1; otherwise shift in 0.
REQ-016 At edge E33 (counter==32), ON SHALL apply sign fix-up, register result_o, and enter END.
- Quotient negated iff signed and op1[31]^op2[31].
- Remainder negated iff signed and op1[31].
REQ-017 BYZERO SHALL register result_o=0 and enter END on the next edge (E1).
REQ-018 In END, ready_o SHALL be 1 and result_o SHALL hold.
- start_i=0 at an edge -> FREE, with ready_o=0 and result_o=0.
- start_i=1 -> stay in END.
REQ-019 annul_i=1 in ON or BYZERO SHALL force FREE at the next edge, with ready_o=0 and result_o=0; annul_i SHALL be ignored in END.
REQ-020 Latency (acceptance edge to ready_o high) SHALL be exactly 33 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-022 ready_o and result_o SHALL be registered outputs with no combinational path from inputs.
REQ-023 After returning to FREE, a new request SHALL be accepted at the very next edge.

Reset
REQ-024 rst low SHALL immediately force state FREE, counter 0, ready_o=0, result_o=0, and all operand registers 0, regardless of state, including mid-ON.
REQ-025 After rst deasserts, the first edge SHALL behave as FREE.

Structure
REQ-026 State encodings (DivFree, DivByZero, DivOn, DivEnd) and DivResultReady/DivResultNotReady, DivStart/DivStop SHALL be defined in the shared defines include, not locally.
REQ-027 The compare-subtract step SHALL be a combinational sub-module div_step (33-bit partial remainder in, next partial remainder and quotient bit out); the FSM, counter and sign logic SHALL stay in div_ctrl.

Verification
REQ-028 The bench SHALL cover: DIVU 100/7 -> ready_o 33 cycles after E0; result_o = {0x00000002, 0x0000000E}.
REQ-029 The bench SHALL cover: DIV -7/2 (0xFFFFFFF9/0x00000002) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
REQ-030 The bench SHALL cover: DIVU 5/0 -> ready_o 1 cycle after E0; result_o = 0; start_i dropped -> FREE next edge, ready_o=0.
REQ-031 The bench SHALL cover these boundary cases:
- DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
- DIVU 0xFFFFFFFF/1 -> {0x00000000, 0xFFFFFFFF}.
REQ-032 The bench SHALL cover: annul_i pulsed at counter==10 -> FREE next edge, ready_o never rises; new DIVU 9/3 accepted the following edge -> {0, 3} after 33 cycles.
REQ-033 The bench SHALL cover: rst low mid-ON (counter==20), asynchronously between edges -> ready_o=0 and result_o=0 immediately; after release, DIVU 8/2 -> {0, 4}.
